// File: rtl/button_reset_conditioner_pkg.sv
// button_reset_conditioner_pkg: state encodings and counter-width helper
// Shared by the debouncer and the reset conditioner top.
package button_reset_conditioner_pkg;
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_e;
   typedef enum logic [1:0] {STRETCH, RUN, HOLD} rst_state_e;
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/button_reset_conditioner_debouncer.sv
// button_reset_conditioner_debouncer: synchroniser, debounce FSM and press/release pulses
// Ports:
//   CLK        clock
//   RESET      asynchronous active-low reset
//   btn_i      raw asynchronous button pin
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse on accepted press
//   release_o  one-cycle pulse on accepted release
module button_reset_conditioner_debouncer
   import button_reset_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic CLK,
   input  logic RESET,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);
   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q;
   db_state_e state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic p, level_q, level_d, press_q, press_d, release_q, release_d;
   // the chain resets to the released pin level so no phantom press follows reset
   assign p = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         sync_q    <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
         state_q   <= RELEASED;
         dcnt_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   // the counter stops at LAST because the state always leaves the wait there
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         RELEASED:     if (p) begin
                          state_d = PRESS_WAIT;
                          dcnt_d  = '0;
                       end
         PRESS_WAIT:   if (!p) state_d = RELEASED;
                       else if (dcnt_q == LAST) state_d = PRESSED;
                       else dcnt_d = dcnt_q + DW'(1);
         PRESSED:      if (!p) begin
                          state_d = RELEASE_WAIT;
                          dcnt_d  = '0;
                       end
         RELEASE_WAIT: if (p) state_d = PRESSED;
                       else if (dcnt_q == LAST) state_d = RELEASED;
                       else dcnt_d = dcnt_q + DW'(1);
      endcase
   end
   always_comb begin
      level_d   = state_d inside {PRESSED, RELEASE_WAIT};
      press_d   = state_q == PRESS_WAIT && state_d == PRESSED;
      release_d = state_q == RELEASE_WAIT && state_d == RELEASED;
   end
   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
endmodule

// File: rtl/button_reset_conditioner.sv
// button_reset_conditioner: debounced reset button plus stretched, sync-deasserted reset
// Ports:
//   CLK          clock
//   RESET        asynchronous active-low reset (power-up)
//   BTN          raw asynchronous pushbutton pin
//   RST_OUT      active-high downstream reset, async assert, sync deassert
//   RST_OUTN     registered inverse of RST_OUT
//   BTN_LEVEL    debounced level, 1 = pressed
//   BTN_PRESS    one-cycle pulse on accepted press
//   BTN_RELEASE  one-cycle pulse on accepted release
module button_reset_conditioner
   import button_reset_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int STRETCH_CYCLES  = 1024,
   parameter bit BTN_ACTIVE_LOW  = 1'b1,
   parameter bit BTN_RESETS      = 1'b1
) (
   input  logic CLK,
   input  logic RESET,
   input  logic BTN,
   output logic RST_OUT,
   output logic RST_OUTN,
   output logic BTN_LEVEL,
   output logic BTN_PRESS,
   output logic BTN_RELEASE
);
   localparam int SW = cnt_width(STRETCH_CYCLES);
   localparam logic [SW-1:0] LAST = SW'(STRETCH_CYCLES - 1);
   rst_state_e state_q, state_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic rst_q, rst_d, rstn_q;
   button_reset_conditioner_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
   ) u_deb (
      .CLK      (CLK),
      .RESET    (RESET),
      .btn_i    (BTN),
      .level_o  (BTN_LEVEL),
      .press_o  (BTN_PRESS),
      .release_o(BTN_RELEASE)
   );
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         state_q <= STRETCH;
         scnt_q  <= '0;
         rst_q   <= 1'b1;
         rstn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         rst_q   <= rst_d;
         rstn_q  <= ~rst_d;
      end
   // a press held during the stretch parks in HOLD so the full stretch restarts on release
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      case (state_q)
         STRETCH: begin
            scnt_d = scnt_q + SW'(1);
            if (BTN_RESETS && BTN_LEVEL) state_d = HOLD;
            else if (scnt_q == LAST) state_d = RUN;
         end
         RUN:     if (BTN_RESETS && BTN_PRESS) state_d = HOLD;
         HOLD:    if (!BTN_LEVEL) begin
                     state_d = STRETCH;
                     scnt_d  = '0;
                  end
         default: state_d = STRETCH;
      endcase
   end
   always_comb rst_d = state_d != RUN;
   assign RST_OUT  = rst_q;
   assign RST_OUTN = rstn_q;
endmodule
